// File: rtl/tr_pkg.sv
// Shared types and default timing constants for the tracking-regulator stepper sequencer.
package tr_pkg;

  typedef enum logic [1:0] {
    ZoneHold = 2'd0,
    ZoneSlow = 2'd1,
    ZoneFast = 2'd2
  } zone_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSetup = 2'd1,
    StPulse = 2'd2,
    StGap   = 2'd3
  } state_t;

  localparam int unsigned DefaultDivFast  = 1000;
  localparam int unsigned DefaultDivSlow  = 10000;
  localparam int unsigned DefaultPulseW   = 50;
  localparam int unsigned DefaultDirSetup = 25;

endpackage

// File: rtl/tr_zone_classifier.sv
// Error magnitude/sign against the setpoint, classified into HOLD/SLOW/FAST zones and
// registered on each accepted ADC sample.
module tr_zone_classifier
  import tr_pkg::*;
#(
  parameter int unsigned XW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          data_valid,
  input  logic [XW-1:0] x,
  input  logic [XW-1:0] x0,
  input  logic [XW-1:0] dx1,
  input  logic [XW-1:0] dx2,
  output zone_t         zone,
  output logic          req_dir
);

  logic signed [XW:0] err;
  logic        [XW:0] neg_err;
  logic      [XW-1:0] err_abs;
  zone_t              zone_d, zone_q;
  logic               req_dir_d, req_dir_q;

  always_comb begin
    err     = $signed({1'b0, x}) - $signed({1'b0, x0});
    neg_err = -err;
    // Magnitude never exceeds 2^XW-1, so dropping the top bit is lossless
    err_abs = err[XW] ? neg_err[XW-1:0] : err[XW-1:0];

    if (err_abs <= dx1) begin
      zone_d = ZoneHold;
    end else if (err_abs <= dx2) begin
      zone_d = ZoneSlow;
    end else begin
      zone_d = ZoneFast;
    end
    req_dir_d = !err[XW] && (err != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zone_q    <= ZoneHold;
      req_dir_q <= 1'b0;
    end else if (data_valid && enable) begin
      zone_q    <= zone_d;
      req_dir_q <= req_dir_d;
    end
  end

  assign zone    = zone_q;
  assign req_dir = req_dir_q;

endmodule

// File: rtl/tr_step_sequencer.sv
// Stepper-drive sequencer: turns the registered error zone into timed step pulses with
// direction setup, driver enable and a signed step position count.
module tr_step_sequencer
  import tr_pkg::*;
#(
  parameter int unsigned XW        = 12,
  parameter int unsigned DIV_FAST  = DefaultDivFast,
  parameter int unsigned DIV_SLOW  = DefaultDivSlow,
  parameter int unsigned PULSE_W   = DefaultPulseW,
  parameter int unsigned DIR_SETUP = DefaultDirSetup,
  parameter int unsigned PW        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          data_valid,
  input  logic [XW-1:0] x,
  input  logic [XW-1:0] x0,
  input  logic [XW-1:0] dx1,
  input  logic [XW-1:0] dx2,
  output logic          drv_SM,
  output logic          drv_step,
  output logic          drv_dir,
  output logic          busy,
  output logic [PW-1:0] pos_cnt
);

  localparam int unsigned CW = $clog2(DIV_SLOW);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] pos_t;

  // Counter runs from the pulse rising edge; GAP ends two short of the period so the
  // single IDLE decision cycle lands the next rising edge exactly one period later.
  localparam cnt_t SetupLast = cnt_t'(DIR_SETUP - 1);
  localparam cnt_t PulseLast = cnt_t'(PULSE_W - 1);
  localparam cnt_t FastLast  = cnt_t'(DIV_FAST - 2);
  localparam cnt_t SlowLast  = cnt_t'(DIV_SLOW - 2);

  zone_t  zone;
  logic   req_dir;

  state_t state_d, state_q;
  cnt_t   cnt_d, cnt_q;
  cnt_t   gap_last_d, gap_last_q;
  logic   dir_d, dir_q;
  logic   sm_d, sm_q;
  pos_t   pos_d, pos_q;
  pos_t   pos_step;

  tr_zone_classifier #(
    .XW(XW)
  ) u_classifier (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .data_valid(data_valid),
    .x         (x),
    .x0        (x0),
    .dx1       (dx1),
    .dx2       (dx2),
    .zone      (zone),
    .req_dir   (req_dir)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + cnt_t'(1);
    gap_last_d = gap_last_q;
    dir_d      = dir_q;
    pos_d      = pos_q;
    pos_step   = dir_d ? pos_q + pos_t'(1) : pos_q - pos_t'(1);

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (enable && (zone != ZoneHold)) begin
          gap_last_d = (zone == ZoneFast) ? FastLast : SlowLast;
          if (req_dir != dir_q) begin
            dir_d   = req_dir;
            state_d = StSetup;
          end else begin
            state_d = StPulse;
            pos_d   = pos_step;
          end
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) begin
          cnt_d   = '0;
          state_d = StPulse;
          pos_d   = pos_step;
        end
      end
      StPulse: begin
        if (cnt_q == PulseLast) begin
          state_d = StGap;
        end
      end
      StGap: begin
        if (cnt_q == gap_last_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Driver enable may only drop while idle so a step in flight is never cut off
    sm_d = enable || (sm_q && (state_q != StIdle));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      gap_last_q <= '0;
      dir_q      <= 1'b0;
      sm_q       <= 1'b0;
      pos_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gap_last_q <= gap_last_d;
      dir_q      <= dir_d;
      sm_q       <= sm_d;
      pos_q      <= pos_d;
    end
  end

  assign drv_step = (state_q == StPulse);
  assign busy     = (state_q != StIdle);
  assign drv_dir  = dir_q;
  assign drv_SM   = sm_q;
  assign pos_cnt  = pos_q;

endmodule
